jk_input_cond: RTL and testbench
================================

JK_INPUT_COND -- requirements
Module: jk_input_cond

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 200_000, the number of consecutive clock cycles a changed level must hold before it is accepted (20 ms at 10 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 18, the debounce counter width; it must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 Port Clk, input, 1 bit: single system clock (10 MHz); all state SHALL update on its rising edge only.
REQ-004 Port Reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port J_raw, input, 1 bit: asynchronous, bouncing pushbutton level for the J channel.
REQ-006 Port K_raw, input, 1 bit: asynchronous, bouncing pushbutton level for the K channel.
REQ-007 Port J, output, 1 bit: debounced J level, registered, driving the downstream JK flip-flop J input.
REQ-008 Port K, output, 1 bit: debounced K level, registered, driving the downstream JK flip-flop K input.
REQ-009 Port J_rise, output, 1 bit: single-cycle pulse marking an accepted 0->1 transition on J.
REQ-010 Port K_rise, output, 1 bit: single-cycle pulse marking an accepted 0->1 transition on K.

Function
REQ-011 Each channel SHALL pass its raw input through a two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-012 Each channel SHALL hold an independent CNT_W-bit counter; channels SHALL NOT share state.
REQ-013 On each edge where s2 equals the stable output, the channel counter SHALL load 0.
REQ-014 On each edge where s2 differs from the stable output and cnt < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 On the edge where s2 differs from the stable output and cnt == DEBOUNCE_CYCLES-1, the stable output SHALL load s2 and the counter SHALL load 0.
REQ-016 Latency: take the edge that first samples a new raw level into s1 as edge 1. If the level holds, the output SHALL change on edge DEBOUNCE_CYCLES+2, and no earlier.
REQ-017 A return of s2 to the stable value for even one cycle before acceptance (a bounce) SHALL restart the count from 0.
REQ-018 The counter SHALL never exceed DEBOUNCE_CYCLES-1, and SHALL never wrap.
REQ-019 J_rise/K_rise SHALL be high for exactly one cycle: the same cycle in which the corresponding stable output goes 0->1. They SHALL be low at all other times, including on 1->0 acceptances.
REQ-020 Simultaneous acceptance on J and K in the same cycle SHALL update both outputs and both pulses in that cycle.

Reset
REQ-021 With Reset_n low at a rising Clk edge, s1, s2, counters, J, K, J_rise and K_rise SHALL all load 0.
REQ-022 Reset SHALL have no effect between clock edges.
REQ-023 Reset asserted mid-count SHALL discard the partial count. After release, counting SHALL restart from 0 against stable value 0.
REQ-024 If a raw input is held high through reset, the channel SHALL accept it DEBOUNCE_CYCLES+2 edges after the first edge with Reset_n high, and SHALL produce a rise pulse.

Configuration
REQ-025 Macro JK_INPUT_COND_RISE_EN SHALL control the edge-detect logic.
REQ-026 With JK_INPUT_COND_RISE_EN defined, J_rise and K_rise SHALL behave per REQ-019.
REQ-027 Without JK_INPUT_COND_RISE_EN, J_rise and K_rise SHALL be constant 0 and no pulse registers SHALL be synthesized. J and K behaviour is unchanged either way.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-028 Reset: Reset_n=0 for 2 edges with J_raw=K_raw=1 -> J=K=0 and pulses 0 throughout reset; J=K=1 on the 6th edge after release.
REQ-029 Clean press: J_raw 0->1 held -> J=1 on edge 6 counted from the first sampling edge; J_rise=1 for exactly that cycle.
REQ-030 Bounce: J_raw pattern 1,1,1,0,1,1,1,1,1,1 per cycle -> J stays 0 through the glitch; J=1 only after 4 consecutive counting edges following the 0.
REQ-031 Release: J=1 steady, J_raw 1->0 held -> J=0 on edge 6; J_rise stays 0.
REQ-032 Simultaneous: J_raw and K_raw rise on the same edge -> J, K, J_rise and K_rise all assert on the same edge 6.
REQ-033 Mid-count reset: J_raw=1, Reset_n pulsed low at count 2 -> J=0, with acceptance 6 edges after release; build without the macro -> pulses stay 0 in all scenarios above.

Source files
------------

// File: rtl/jk_input_cond.sv
// Debounce and synchronize the J/K pushbutton inputs that feed the downstream JK flip-flop.
// Define JK_INPUT_COND_RISE_EN to build the single-cycle rising-edge pulses (J_rise/K_rise).

module jk_input_cond_chan #(
    parameter int DEBOUNCE_CYCLES = 200_000,
    parameter int CNT_W           = 18
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic lvl_o,
    output logic rise_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differs, accept;

    // A single cycle of agreement with the stable level clears the count.
    always_comb begin
        differs = (s2_q != lvl_q);
        accept  = differs && (cnt_q == CNT_MAX);
        cnt_d   = '0;
        lvl_d   = lvl_q;
        if (accept)
            lvl_d = s2_q;
        else if (differs)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign lvl_o = lvl_q;

`ifdef JK_INPUT_COND_RISE_EN
    logic rise_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            rise_q <= 1'b0;
        else
            rise_q <= accept && s2_q;
    end

    assign rise_o = rise_q;
`else
    assign rise_o = 1'b0;
`endif
endmodule

module jk_input_cond #(
    parameter int DEBOUNCE_CYCLES = 200_000,
    parameter int CNT_W           = 18
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic J_raw,
    input  logic K_raw,
    output logic J,
    output logic K,
    output logic J_rise,
    output logic K_rise
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0] raw, lvl, rise;

    assign raw = {K_raw, J_raw};

    // Lane 0 is J, lane 1 is K; lanes share no state.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_ch
        jk_input_cond_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk_i  (Clk),
            .rst_n_i(Reset_n),
            .raw_i  (raw[g]),
            .lvl_o  (lvl[g]),
            .rise_o (rise[g])
        );
    end

    assign J      = lvl[0];
    assign K      = lvl[1];
    assign J_rise = rise[0];
    assign K_rise = rise[1];
endmodule

// File: tb/tb_jk_input_cond.sv
// Directed bench for jk_input_cond (DEBOUNCE_CYCLES=4): stimulus queues the expected
// {J,K,J_rise,K_rise} after each edge, a monitor pops and compares 1 time unit after that edge.

module tb_jk_input_cond;
`ifdef JK_INPUT_COND_RISE_EN
    localparam logic RISE = 1'b1;
`else
    localparam logic RISE = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset_n, J_raw, K_raw;
    logic J, K, J_rise, K_rise;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_e;

    jk_input_cond #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .J_raw  (J_raw),
        .K_raw  (K_raw),
        .J      (J),
        .K      (K),
        .J_rise (J_rise),
        .K_rise (K_rise)
    );

    always #5 Clk = ~Clk;

    // Monitor: one expected entry per rising edge.
    always @(posedge Clk) begin
        #1;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks = checks + 1;
            if ({J, K, J_rise, K_rise} === mon_e)
                passes = passes + 1;
            else
                $display("FAIL outputs edge %0d: got {J,K,Jr,Kr}=%b want %b",
                         cyc, {J, K, J_rise, K_rise}, mon_e);
        end
    end

    // e = {J, K, J_rise, K_rise} expected after the coming edge.
    task automatic st(input logic r, input logic jr, input logic kr, input logic [3:0] e);
        Reset_n = r;
        J_raw   = jr;
        K_raw   = kr;
        exp_q.push_back(e & {2'b11, RISE, RISE});
        @(posedge Clk);
        #2;
    endtask

    task automatic rep(input int n, input logic r, input logic jr, input logic kr,
                       input logic [3:0] e);
        for (int i = 0; i < n; i++) st(r, jr, kr, e);
    endtask

    initial begin
        // Reset with both raw inputs high, then acceptance on the 6th edge after release.
        rep(2, 0, 1, 1, 4'b0000);
        rep(5, 1, 1, 1, 4'b0000);
        st (1, 1, 1, 4'b1111);
        st (1, 1, 1, 4'b1100);

        // Release J only, then K only: no rise pulses on 1->0.
        rep(5, 1, 0, 1, 4'b1100);
        st (1, 0, 1, 4'b0100);
        rep(5, 1, 0, 0, 4'b0100);
        st (1, 0, 0, 4'b0000);
        st (1, 0, 0, 4'b0000);

        // Clean J press and release.
        rep(5, 1, 1, 0, 4'b0000);
        st (1, 1, 0, 4'b1010);
        st (1, 1, 0, 4'b1000);
        rep(5, 1, 0, 0, 4'b1000);
        st (1, 0, 0, 4'b0000);

        // Bounce 1,1,1,0,1,1,1,1,1,1: the glitch lands just before acceptance would occur.
        rep(3, 1, 1, 0, 4'b0000);
        st (1, 0, 0, 4'b0000);
        rep(5, 1, 1, 0, 4'b0000);
        st (1, 1, 0, 4'b1010);
        st (1, 1, 0, 4'b1000);
        rep(5, 1, 0, 0, 4'b1000);
        st (1, 0, 0, 4'b0000);

        // Simultaneous press and release of J and K.
        rep(5, 1, 1, 1, 4'b0000);
        st (1, 1, 1, 4'b1111);
        st (1, 1, 1, 4'b1100);
        rep(5, 1, 0, 0, 4'b1100);
        st (1, 0, 0, 4'b0000);
        st (1, 0, 0, 4'b0000);

        // Mid-count reset at count 2 with J_raw held high.
        rep(4, 1, 1, 0, 4'b0000);
        st (0, 1, 0, 4'b0000);
        rep(5, 1, 1, 0, 4'b0000);
        st (1, 1, 0, 4'b1010);
        st (1, 1, 0, 4'b1000);

        // Every queued expectation must have been consumed by the monitor.
        @(posedge Clk);
        #3;
        checks = checks + 1;
        if (exp_q.size() == 0)
            passes = passes + 1;
        else
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
